// File: rtl/int_img_pkg.sv
// Shared defaults, width helpers and FSM state
// for the streaming integral-image block.
package int_img_pkg;

    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;
    localparam int DEF_PIX_W  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int ii_width(
        input int pix_w,
        input int w,
        input int h
    );
        return pix_w + $clog2(w * h);
    endfunction

    function automatic int sq_width(
        input int pix_w,
        input int w,
        input int h
    );
        return 2 * pix_w + $clog2(w * h);
    endfunction

endpackage

// File: rtl/int_img_linebuf.sv
// One-row line buffer: combinational read port,
// registered write port.
module int_img_linebuf #(
    parameter int DEPTH = 320,
    parameter int DW    = 25,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    assign rd_data = mem[rd_addr];

    // write the column's new integral after it was read
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/int_img_stream.sv
// Raster-order integral-image generator, one pixel per
// cycle, with optional squared-pixel integral.
module int_img_stream
    import int_img_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int SQ_EN  = 1,
    parameter int II_W   = ii_width(PIX_W, WIDTH, HEIGHT),
    parameter int SQ_W   = sq_width(PIX_W, WIDTH, HEIGHT),
    localparam int RW    = $clog2(HEIGHT),
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             ii_valid,
    input  logic             ii_ready,
    output logic [II_W-1:0]  ii_data,
    output logic [SQ_W-1:0]  ii_sq_data,
    output logic [RW-1:0]    ii_row,
    output logic [CW-1:0]    ii_col,
    output logic             ii_eof,
    output logic             frame_err
);

    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam int SQP_W = 2 * PIX_W;

    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [II_W-1:0] rowsum_q, rowsum_d;
    logic [II_W-1:0] base_sum, lb_rd, ii_sum;
    logic accept, proc, err;
    logic last_col, last_pix, row0;

    assign pix_ready = ~ii_valid | ii_ready;
    assign accept    = pix_valid & pix_ready;

    // a sof pixel always restarts at (0,0)
    assign cur_col  = pix_sof ? '0 : col_q;
    assign cur_row  = pix_sof ? '0 : row_q;
    assign row0     = (cur_row == '0);
    assign last_col = (cur_col == LAST_COL);
    assign last_pix = last_col & (cur_row == LAST_ROW);

    assign base_sum = pix_sof ? '0 : rowsum_q;
    assign ii_sum   = base_sum + II_W'(pix_data)
                    + (row0 ? '0 : lb_rd);
    assign rowsum_d = last_col ? '0
                    : base_sum + II_W'(pix_data);

    int_img_linebuf #(
        .DEPTH (WIDTH),
        .DW    (II_W)
    ) u_lb_ii (
        .clock   (clock),
        .wr_en   (proc),
        .wr_addr (cur_col),
        .wr_data (ii_sum),
        .rd_addr (cur_col),
        .rd_data (lb_rd)
    );

    // frame position and state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // next position, sof/frame checks
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        proc    = 1'b0;
        err     = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    proc = pix_sof;
                    err  = ~pix_sof;
                end
                ACTIVE: begin
                    proc = 1'b1;
                    err  = pix_sof;
                end
            endcase
            if (proc) begin
                if (last_pix) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = ACTIVE;
                    col_d   = last_col ? '0 : cur_col + 1'b1;
                    row_d   = last_col ? cur_row + 1'b1 : cur_row;
                end
            end
        end
    end

    // row accumulator and output register
    always_ff @(posedge clock) begin
        if (reset) begin
            rowsum_q  <= '0;
            ii_valid  <= 1'b0;
            ii_data   <= '0;
            ii_row    <= '0;
            ii_col    <= '0;
            ii_eof    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err;
            if (proc) begin
                rowsum_q <= rowsum_d;
                ii_valid <= 1'b1;
                ii_data  <= ii_sum;
                ii_row   <= cur_row;
                ii_col   <= cur_col;
                ii_eof   <= last_pix;
            end else if (ii_ready) begin
                ii_valid <= 1'b0;
            end
        end
    end

    generate
        if (SQ_EN != 0) begin : g_sq
            logic [SQP_W-1:0] pix_ext, sq_pix;
            logic [SQ_W-1:0] rowsq_q, sq_base;
            logic [SQ_W-1:0] sq_rd, sq_sum;

            assign pix_ext = SQP_W'(pix_data);
            assign sq_pix  = pix_ext * pix_ext;
            assign sq_base = pix_sof ? '0 : rowsq_q;
            assign sq_sum  = sq_base + SQ_W'(sq_pix)
                           + (row0 ? '0 : sq_rd);

            int_img_linebuf #(
                .DEPTH (WIDTH),
                .DW    (SQ_W)
            ) u_lb_sq (
                .clock   (clock),
                .wr_en   (proc),
                .wr_addr (cur_col),
                .wr_data (sq_sum),
                .rd_addr (cur_col),
                .rd_data (sq_rd)
            );

            // squared row accumulator and output
            always_ff @(posedge clock) begin
                if (reset) begin
                    rowsq_q    <= '0;
                    ii_sq_data <= '0;
                end else if (proc) begin
                    rowsq_q    <= last_col ? '0
                                : sq_base + SQ_W'(sq_pix);
                    ii_sq_data <= sq_sum;
                end
            end
        end else begin : g_nosq
            assign ii_sq_data = '0;
        end
    endgenerate

endmodule

// File: tb/tb_int_img_stream.sv
// Directed/table and scenario bench for int_img_stream
// (4x3 instance plus a default-size instance).
module tb_int_img_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void chk(
        input string name,
        input longint got,
        input longint exp
    );
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endfunction

    // small 4x3 instance
    logic        reset, pix_valid, pix_ready, pix_sof;
    logic [7:0]  pix_data;
    logic        ii_valid, ii_ready, ii_eof, frame_err;
    logic [11:0] ii_data;
    logic [19:0] ii_sq_data;
    logic [1:0]  ii_row, ii_col;

    int_img_stream #(
        .WIDTH(4), .HEIGHT(3), .PIX_W(8), .SQ_EN(1)
    ) dut (
        .clock(clock), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_sof(pix_sof),
        .ii_valid(ii_valid), .ii_ready(ii_ready),
        .ii_data(ii_data), .ii_sq_data(ii_sq_data),
        .ii_row(ii_row), .ii_col(ii_col),
        .ii_eof(ii_eof), .frame_err(frame_err)
    );

    // default 320x240 instance
    logic        b_reset, b_valid, b_ready, b_sof;
    logic [7:0]  b_pix;
    logic        b_ii_valid, b_ii_ready, b_eof, b_err;
    logic [24:0] b_ii;
    logic [32:0] b_sq;
    logic [7:0]  b_row;
    logic [8:0]  b_col;

    int_img_stream dut_big (
        .clock(clock), .reset(b_reset),
        .pix_valid(b_valid), .pix_ready(b_ready),
        .pix_data(b_pix), .pix_sof(b_sof),
        .ii_valid(b_ii_valid), .ii_ready(b_ii_ready),
        .ii_data(b_ii), .ii_sq_data(b_sq),
        .ii_row(b_row), .ii_col(b_col),
        .ii_eof(b_eof), .frame_err(b_err)
    );

    typedef struct {
        bit sof; int pix; int ii; int sq;
        int row; int col; bit eof;
    } vec_t;

    typedef struct { bit sof; int pix; } in_t;
    typedef struct {
        longint ii; longint sq;
        int row; int col; bit eof;
    } out_t;

    in_t  inq[$];
    out_t expq[$];
    int   exp_err;

    // summed-area reference: direct 2-D sums over the frame
    int m_act, m_r, m_c;
    int m_px [3][4];

    function automatic void model_push(input bit s, input int p);
        longint a, q;
        out_t o;
        inq.push_back('{sof: s, pix: p});
        if (s) begin
            if (m_act != 0) exp_err++;
            m_act = 1; m_r = 0; m_c = 0;
        end else if (m_act == 0) begin
            exp_err++;
            return;
        end
        m_px[m_r][m_c] = p;
        a = 0; q = 0;
        for (int i = 0; i <= m_r; i++)
            for (int j = 0; j <= m_c; j++) begin
                a += m_px[i][j];
                q += m_px[i][j] * m_px[i][j];
            end
        o.ii = a; o.sq = q; o.row = m_r; o.col = m_c;
        o.eof = (m_r == 2 && m_c == 3);
        expq.push_back(o);
        m_c++;
        if (m_c == 4) begin
            m_c = 0; m_r++;
            if (m_r == 3) m_act = 0;
        end
    endfunction

    task automatic push_frame(input int base, input bit rnd);
        for (int k = 0; k < 12; k++)
            model_push(k == 0,
                rnd ? int'($urandom_range(0, 255)) : base + k);
    endtask

    // drive inq under handshake, check outputs in order
    task automatic run_stream(input bit rnd, input string nm);
        int n_in = 0, n_out = 0, errs = 0, ncyc = 0;
        bit stalled = 0;
        out_t held;
        while ((n_in < inq.size() || n_out < expq.size())
               && ncyc < 400) begin
            ii_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n_in < inq.size()) begin
                pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                pix_sof   = inq[n_in].sof;
                pix_data  = 8'(inq[n_in].pix);
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clock);
            if (frame_err) errs++;
            if (stalled) begin
                chk({nm, "_hold_ii"}, ii_data, held.ii);
                chk({nm, "_hold_sq"}, ii_sq_data, held.sq);
                chk({nm, "_hold_pos"}, {ii_row, ii_col},
                    {held.row[1:0], held.col[1:0]});
                chk({nm, "_hold_eof"}, ii_eof, held.eof);
            end
            if (ii_valid && !ii_ready)
                chk({nm, "_stall_rdy"}, pix_ready, 0);
            if (ii_valid && ii_ready) begin
                if (n_out < expq.size()) begin
                    chk({nm, "_ii"}, ii_data, expq[n_out].ii);
                    chk({nm, "_sq"}, ii_sq_data, expq[n_out].sq);
                    chk({nm, "_row"}, ii_row, expq[n_out].row);
                    chk({nm, "_col"}, ii_col, expq[n_out].col);
                    chk({nm, "_eof"}, ii_eof, expq[n_out].eof);
                end else begin
                    chk({nm, "_extra_out"}, n_out, expq.size() - 1);
                end
                n_out++;
            end
            stalled = ii_valid && !ii_ready;
            held.ii = ii_data; held.sq = ii_sq_data;
            held.row = ii_row; held.col = ii_col;
            held.eof = ii_eof;
            if (pix_valid && pix_ready) n_in++;
            @(posedge clock); #1;
            ncyc++;
        end
        chk({nm, "_done"}, n_in + n_out, inq.size() + expq.size());
        pix_valid = 1'b0;
        ii_ready  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (frame_err) errs++;
            if (ii_valid) chk({nm, "_late_out"}, ii_valid, 0);
        end
        chk({nm, "_errs"}, errs, exp_err);
        @(posedge clock); #1;
        inq.delete(); expq.delete(); exp_err = 0;
    endtask

    vec_t vt [24];
    int p2 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 255};
    int e2 [12] = '{1, 3, 6, 10, 6, 14, 24, 36, 15, 33, 54, 321};
    int s2 [12] = '{1, 5, 14, 30, 26, 66, 124, 204,
                    107, 247, 426, 65531};

    task automatic run_big();
        int bin = 0, bout = 0, beof = 0;
        b_valid = 1'b1; b_sof = 1'b1; b_pix = 8'd255;
        for (int cyc = 0; cyc < 77000 && bout < 76800; cyc++) begin
            @(negedge clock);
            if (b_ii_valid) begin
                bout++;
                if (b_eof) beof++;
                if (bout == 1) begin
                    chk("big_first_ii", b_ii, 255);
                    chk("big_first_sq", b_sq, 65025);
                    chk("big_first_pos", {b_row, b_col}, 0);
                end
                if (bout == 76800) begin
                    chk("big_last_ii", b_ii, 19584000);
                    chk("big_last_sq", b_sq, 64'd4993920000);
                    chk("big_last_row", b_row, 239);
                    chk("big_last_col", b_col, 319);
                    chk("big_last_eof", b_eof, 1);
                end
            end
            if (b_valid && b_ready) bin++;
            @(posedge clock); #1;
            b_sof = 1'b0;
            if (bin == 76800) b_valid = 1'b0;
        end
        chk("big_count", bout, 76800);
        chk("big_eofs", beof, 1);
    endtask

    task automatic run_small();
        // table: all-ones frame then a hand-computed frame
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                vt[r*4+c] = '{r == 0 && c == 0, 1, (r+1)*(c+1),
                              (r+1)*(c+1), r, c, r == 2 && c == 3};
                vt[12+r*4+c] = '{r == 0 && c == 0, p2[r*4+c],
                                 e2[r*4+c], s2[r*4+c], r, c,
                                 r == 2 && c == 3};
            end
        ii_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            pix_valid = 1'b1;
            pix_sof   = vt[i].sof;
            pix_data  = 8'(vt[i].pix);
            @(posedge clock);
            @(negedge clock);
            chk("tab_valid", ii_valid, 1);
            chk("tab_ready", pix_ready, 1);
            chk("tab_ii", ii_data, vt[i].ii);
            chk("tab_sq", ii_sq_data, vt[i].sq);
            chk("tab_row", ii_row, vt[i].row);
            chk("tab_col", ii_col, vt[i].col);
            chk("tab_eof", ii_eof, vt[i].eof);
            chk("tab_err", frame_err, 0);
        end
        pix_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("tab_drain", ii_valid, 0);
        @(posedge clock); #1;

        // random pixels, random backpressure
        push_frame(0, 1);
        run_stream(1, "rnd");

        // sof reasserted at (1,2)
        for (int k = 0; k < 6; k++) model_push(k == 0, 10 + k);
        model_push(1, 77);
        for (int k = 1; k < 12; k++) model_push(0, 20 + k);
        push_frame(0, 1);
        run_stream(1, "resof");

        // pixels while idle without sof
        for (int k = 0; k < 3; k++) model_push(0, 40 + k);
        push_frame(50, 0);
        run_stream(0, "idle");

        // reset at (2,1) with a sample pending
        for (int k = 0; k < 8; k++) model_push(k == 0, 200 + k);
        run_stream(0, "pre_rst");
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 8'd9;
        ii_ready = 1'b1;
        @(posedge clock); #1;
        pix_data = 8'd10;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_pending", ii_valid, 1);
        chk("rst_pending_pos", {ii_row, ii_col}, 4'b1000);
        @(posedge clock); #1;
        reset = 1'b0; pix_valid = 1'b0;
        @(negedge clock);
        chk("rst_valid", ii_valid, 0);
        chk("rst_ii", ii_data, 0);
        chk("rst_sq", ii_sq_data, 0);
        chk("rst_pos", {ii_row, ii_col}, 0);
        chk("rst_eof", ii_eof, 0);
        chk("rst_err", frame_err, 0);
        @(posedge clock); #1;
        m_act = 0;
        model_push(0, 5);
        push_frame(100, 0);
        run_stream(0, "post_rst");
    endtask

    initial begin
        m_act = 0; m_r = 0; m_c = 0; exp_err = 0;
        reset = 1'b1; b_reset = 1'b1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        ii_ready = 1'b1;
        b_valid = 1'b0; b_sof = 1'b0; b_pix = '0;
        b_ii_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", ii_valid, 0);
        chk("reset_ii", ii_data, 0);
        chk("reset_sq", ii_sq_data, 0);
        chk("reset_pos", {ii_row, ii_col}, 0);
        chk("reset_eof", ii_eof, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_ready", pix_ready, 1);
        chk("big_reset_valid", b_ii_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0; b_reset = 1'b0;
        fork
            run_big();
            run_small();
        join
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/int_img_stream.md
Name: int_img_stream

Overview:
Streaming integral-image generator. It replaces the combinational whole-frame int_img_calc with a raster-order pipeline that accepts one pixel per cycle under valid/ready flow control. For each pixel it emits the summed-area value and, optionally, the squared-pixel integral needed for Viola-Jones window variance normalisation. It sits between a downscaler output and the scanning-window buffer that feeds vj_pipeline. One instance serves one pyramid level.

Parameters:
WIDTH, 320, pixels per row (>=2)
HEIGHT, 240, rows per frame (>=2)
PIX_W, 8, input pixel width
SQ_EN, 1, 1 = generate squared integral; 0 = ii_sq_data tied to 0 and its logic removed
II_W, PIX_W+$clog2(WIDTH*HEIGHT), integral output width (25 at defaults)
SQ_W, 2*PIX_W+$clog2(WIDTH*HEIGHT), squared-integral output width (33 at defaults)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
pix_valid  input  1  input pixel valid
pix_ready  output  1  block can accept a pixel
pix_data  input  PIX_W  pixel value, unsigned
pix_sof  input  1  start of frame, qualifies the pixel at row 0, col 0
ii_valid  output  1  output sample valid
ii_ready  input  1  downstream accepts the sample
ii_data  output  II_W  integral value at (ii_row, ii_col)
ii_sq_data  output  SQ_W  squared integral at (ii_row, ii_col)
ii_row  output  $clog2(HEIGHT)  row of the output sample
ii_col  output  $clog2(WIDTH)  column of the output sample
ii_eof  output  1  output sample is (HEIGHT-1, WIDTH-1)
frame_err  output  1  one-cycle pulse: pix_sof seen mid-frame, or a pixel without sof while idle

Behaviour:
- Reset (synchronous, active-high, takes priority): ii_valid=0, ii_data=0, ii_sq_data=0, ii_row=0, ii_col=0, ii_eof=0, frame_err=0. Column/row counters = 0, row accumulators = 0, state = IDLE. Line buffer contents are don't-care; row 0 never reads them.
- Handshake: accept = pix_valid & pix_ready; emit = ii_valid & ii_ready. pix_ready = ~ii_valid | ii_ready (single output register, no skid buffer). Output fields hold stable while ii_valid=1 and ii_ready=0.
- Latency: a pixel accepted at cycle N appears with ii_valid=1 at cycle N+1. Full throughput is 1 pixel/cycle when ii_ready is held at 1.
- Arithmetic, all unsigned with zero-extension:
  - rowsum += pix
  - ii = rowsum + lb[col], where lb[col] is zero on row 0
  - lb[col] is then written with ii (read-before-write at the same column)
  - Squared path: sq = pix*pix, same structure with rowsq and a second line buffer. No saturation; widths are sized so that no overflow is possible.
- rowsum and rowsq clear on the accept of col=WIDTH-1.
- State machine:
  - IDLE: an accept with pix_sof=1 is processed as (0,0) and moves to ACTIVE. An accept with pix_sof=0 is dropped (no output) and pulses frame_err.
  - ACTIVE: col increments per accept. At col=WIDTH-1, col wraps to 0 and row increments. The accept at (HEIGHT-1, WIDTH-1) produces ii_eof=1 with that sample and returns to IDLE.
  - ACTIVE with pix_sof=1 on an accept not at (0,0): pulse frame_err, abandon the current frame, and process this pixel as (0,0) of a new frame.
- Back-to-back frames: a sof pixel accepted in the cycle after the eof pixel is legal and produces no bubble.
- reset asserted mid-frame: any pending ii_valid is dropped the next cycle; the next frame requires pix_sof.
- ii_valid=1 with ii_ready=0 and pix_valid=1: pix_ready=0, no state advances.

Decomposition:
- Package int_img_pkg: default WIDTH/HEIGHT/PIX_W, II_W/SQ_W width functions, and the state enum (IDLE, ACTIVE).
- Sub-module int_img_linebuf: parameters DEPTH and DW, with an asynchronous read port and a synchronous write port. The design uses two instances, one for ii and one for sq; the sq instance is generated only when SQ_EN=1.

Test Plan:
- WIDTH=4, HEIGHT=3, all pixels 1, ii_ready=1 -> ii_data(r,c) = (r+1)(c+1); final sample is 12 with ii_eof=1; one output per cycle, latency 1.
- Defaults (320x240), all pixels 255, SQ_EN=1 -> last ii_data = 19584000 and ii_sq_data = 4993920000; no wrap; the (0,0) sample is 255 / 65025.
- Random pixels, random ii_ready (50% duty), 4x3 -> outputs match a software summed-area model in order; outputs held stable while stalled; pix_ready never asserts while stalled with ii_valid=1.
- 4x3 frame, pix_sof reasserted at (1,2) -> frame_err pulses once; that pixel is output as (0,0) with ii_data = its pixel value; the subsequent frame is correct.
- Pixels sent while IDLE with pix_sof=0 -> no ii_valid and one frame_err pulse per pixel; the later sof frame is correct.
- reset asserted at (2,1) of a 4x3 frame, then a clean frame -> all outputs are 0 the cycle after reset; the new frame's results show no residue from row accumulators or line buffers.
